// File: rtl/capture_writer_if.sv
// Sample-memory write bus between the capture writer and the capture RAM.
interface capture_writer_if #(
  parameter int AW = 12,
  parameter int DW = 16
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/capture_writer.sv
// Circular-buffer capture writer: streams ADC samples into a 2^AW-word memory,
// keeps a pre-trigger history and stops once the buffer holds a full record.
module capture_writer #(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DW-1:0]    adc_data,
  input  logic             adc_valid,
  input  logic             arm,
  input  logic             force_trig,
  input  logic [DW-1:0]    trig_level,
  input  logic             trig_falling,
  input  logic [AW-1:0]    pretrig,
  capture_writer_if.master wr_bus,
  output logic [AW-1:0]    start_addr,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0]  ST_IDLE  = 3'd0;
  localparam logic [2:0]  ST_PRE   = 3'd1;
  localparam logic [2:0]  ST_ARMED = 3'd2;
  localparam logic [2:0]  ST_POST  = 3'd3;
  localparam logic [2:0]  ST_DONE  = 3'd4;
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   DEPTH    = CNT_ONE << AW;

  logic [2:0]    state_r,    state_s;
  logic [AW-1:0] ptr_r,      ptr_s;
  logic [AW:0]   cnt_r,      cnt_s;
  logic [AW-1:0] pre_lat_r,  pre_lat_s;
  logic [AW-1:0] start_r,    start_s;
  logic          we_r,       we_s;
  logic [AW-1:0] waddr_r,    waddr_s;
  logic [DW-1:0] wdata_r,    wdata_s;
  logic [DW-1:0] prev_r,     prev_s;
  logic          prev_vld_r, prev_vld_s;
  logic          pend_r,     pend_s;
  logic          busy_r,     busy_s;
  logic          done_r,     done_s;

  logic          capturing_s;
  logic          rise_s;
  logic          fall_s;
  logic          trig_s;
  logic [AW:0]   post_target_s;

  assign capturing_s   = (state_r == ST_PRE) || (state_r == ST_ARMED) || (state_r == ST_POST);
  assign rise_s        = prev_vld_r && (prev_r <  trig_level) && (adc_data >= trig_level);
  assign fall_s        = prev_vld_r && (prev_r >= trig_level) && (adc_data <  trig_level);
  // A force pulse seen without a sample is remembered and fires on the next sample.
  assign trig_s        = force_trig || pend_r || (trig_falling ? fall_s : rise_s);
  // Wide enough that pretrig = 2^AW-1 yields a post count of zero, not a wrap.
  assign post_target_s = DEPTH - {1'b0, pre_lat_r} - CNT_ONE;

  // Next-state, address and write-bus computation.
  always_comb begin
    state_s    = state_r;
    ptr_s      = ptr_r;
    cnt_s      = cnt_r;
    pre_lat_s  = pre_lat_r;
    start_s    = start_r;
    we_s       = 1'b0;
    waddr_s    = waddr_r;
    wdata_s    = wdata_r;
    prev_s     = prev_r;
    prev_vld_s = prev_vld_r;
    pend_s     = pend_r;
    if (arm) begin
      pre_lat_s  = pretrig;
      ptr_s      = {AW{1'b0}};
      waddr_s    = {AW{1'b0}};
      cnt_s      = {(AW+1){1'b0}};
      start_s    = {AW{1'b0}};
      prev_vld_s = 1'b0;
      pend_s     = 1'b0;
      state_s    = (pretrig != {AW{1'b0}}) ? ST_PRE : ST_ARMED;
    end else if (capturing_s && adc_valid) begin
      we_s       = 1'b1;
      waddr_s    = ptr_r;
      wdata_s    = adc_data;
      ptr_s      = ptr_r + ADDR_ONE;
      prev_s     = adc_data;
      prev_vld_s = 1'b1;
      case (state_r)
        ST_PRE: begin
          if ((cnt_r + CNT_ONE) == {1'b0, pre_lat_r}) begin
            cnt_s   = {(AW+1){1'b0}};
            state_s = ST_ARMED;
          end else begin
            cnt_s   = cnt_r + CNT_ONE;
          end
        end
        ST_ARMED: begin
          if (trig_s) begin
            start_s = ptr_r - pre_lat_r;
            pend_s  = 1'b0;
            cnt_s   = {(AW+1){1'b0}};
            state_s = (post_target_s == {(AW+1){1'b0}}) ? ST_DONE : ST_POST;
          end else begin
            state_s = ST_ARMED;
          end
        end
        ST_POST: begin
          if ((cnt_r + CNT_ONE) == post_target_s) begin
            state_s = ST_DONE;
          end else begin
            cnt_s   = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end else if ((state_r == ST_ARMED) && force_trig) begin
      pend_s = 1'b1;
    end else begin
      pend_s = pend_r;
    end
    busy_s = (state_s == ST_PRE) || (state_s == ST_ARMED) || (state_s == ST_POST);
    done_s = (state_s == ST_DONE);
  end

  // State and output registers; reset aborts any capture immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      ptr_r      <= {AW{1'b0}};
      cnt_r      <= {(AW+1){1'b0}};
      pre_lat_r  <= {AW{1'b0}};
      start_r    <= {AW{1'b0}};
      we_r       <= 1'b0;
      waddr_r    <= {AW{1'b0}};
      wdata_r    <= {DW{1'b0}};
      prev_r     <= {DW{1'b0}};
      prev_vld_r <= 1'b0;
      pend_r     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      ptr_r      <= ptr_s;
      cnt_r      <= cnt_s;
      pre_lat_r  <= pre_lat_s;
      start_r    <= start_s;
      we_r       <= we_s;
      waddr_r    <= waddr_s;
      wdata_r    <= wdata_s;
      prev_r     <= prev_s;
      prev_vld_r <= prev_vld_s;
      pend_r     <= pend_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

  assign wr_bus.wr_en   = we_r;
  assign wr_bus.wr_addr = waddr_r;
  assign wr_bus.wr_data = wdata_r;
  assign start_addr     = start_r;
  assign busy           = busy_r;
  assign done           = done_r;

endmodule

// File: tb/tb_capture_writer.sv
// Directed bench for capture_writer at AW=4: pre-trigger, force, falling edge,
// re-arm, asynchronous reset and long ARMED wrap.
module tb_capture_writer;
  localparam int AW = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] adc_data = 16'd0;
  logic          adc_valid = 1'b0;
  logic          arm = 1'b0;
  logic          force_trig = 1'b0;
  logic [DW-1:0] trig_level = 16'd0;
  logic          trig_falling = 1'b0;
  logic [AW-1:0] pretrig = 4'd0;
  logic [AW-1:0] start_addr;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  logic [DW-1:0] mem [16];

  always #5 clk = ~clk;

  capture_writer_if #(.AW(AW), .DW(DW)) wr_bus ();

  capture_writer #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .adc_data(adc_data), .adc_valid(adc_valid),
    .arm(arm), .force_trig(force_trig), .trig_level(trig_level),
    .trig_falling(trig_falling), .pretrig(pretrig), .wr_bus(wr_bus),
    .start_addr(start_addr), .busy(busy), .done(done)
  );

  // Memory model fed from the write bus
  always @(negedge clk) begin
    if (wr_bus.wr_en) begin
      wr_cnt <= wr_cnt + 1;
      mem[wr_bus.wr_addr] <= wr_bus.wr_data;
    end
  end

  task automatic arm_cap(input logic [AW-1:0] pre, input logic fall, input logic [DW-1:0] lvl);
    @(negedge clk);
    arm = 1'b1; pretrig = pre; trig_falling = fall; trig_level = lvl;
    @(negedge clk);
    arm = 1'b0;
    #1;
  endtask

  task automatic send(input logic [DW-1:0] v, input logic frc);
    @(negedge clk);
    adc_valid = 1'b1; adc_data = v; force_trig = frc;
    @(negedge clk);
    adc_valid = 1'b0; force_trig = 1'b0;
    #1;
  endtask

  task automatic pulse_force();
    @(negedge clk);
    force_trig = 1'b1;
    @(negedge clk);
    force_trig = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (wr_bus.wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %0b expected 0", wr_bus.wr_en); end
    checks++; if (wr_bus.wr_addr !== 4'd0) begin errors++; $display("FAIL rst_wr_addr: got %0d expected 0", wr_bus.wr_addr); end
    checks++; if (wr_bus.wr_data !== 16'd0) begin errors++; $display("FAIL rst_wr_data: got %0d expected 0", wr_bus.wr_data); end
    checks++; if (start_addr !== 4'd0) begin errors++; $display("FAIL rst_start: got %0d expected 0", start_addr); end
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL rst_busy_done: got %b expected 00", {busy, done}); end
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_pretrig_rising();
    int base;
    arm_cap(4'd4, 1'b0, 16'd8);
    base = wr_cnt;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pre_busy: got %0b expected 1", busy); end
    for (int v = 0; v < 4; v++) send(16'(v), 1'b0);
    checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL pre_fill: got %b expected 10", {busy, done}); end
    for (int v = 4; v < 9; v++) send(16'(v), 1'b0);
    checks++; if (start_addr !== 4'd4) begin errors++; $display("FAIL pre_start: got %0d expected 4", start_addr); end
    checks++; if (wr_bus.wr_addr !== 4'd8) begin errors++; $display("FAIL pre_trig_addr: got %0d expected 8", wr_bus.wr_addr); end
    for (int v = 9; v < 19; v++) send(16'(v), 1'b0);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL pre_done_early: got %0b expected 0", done); end
    send(16'd19, 1'b0);
    checks++; if ({busy, done} !== 2'b01) begin errors++; $display("FAIL pre_done: got %b expected 01", {busy, done}); end
    checks++; if (wr_cnt - base !== 20) begin errors++; $display("FAIL pre_writes: got %0d expected 20", wr_cnt - base); end
    checks++; if (mem[4] !== 16'd4 || mem[8] !== 16'd8 || mem[3] !== 16'd19) begin
      errors++; $display("FAIL pre_mem: got %0d %0d %0d expected 4 8 19", mem[4], mem[8], mem[3]);
    end
    send(16'd20, 1'b0);
    checks++; if (wr_cnt - base !== 20 || done !== 1'b1 || start_addr !== 4'd4) begin
      errors++; $display("FAIL done_hold: got writes=%0d done=%0b start=%0d expected 20 1 4", wr_cnt - base, done, start_addr);
    end
  endtask

  task automatic test_force();
    int base;
    arm_cap(4'd0, 1'b0, 16'hFFFF);
    base = wr_cnt;
    send(16'd100, 1'b0);
    send(16'd101, 1'b0);
    send(16'd102, 1'b1);
    checks++; if (wr_bus.wr_addr !== 4'd2 || start_addr !== 4'd2) begin
      errors++; $display("FAIL force_start: got addr=%0d start=%0d expected 2 2", wr_bus.wr_addr, start_addr);
    end
    for (int i = 0; i < 14; i++) send(16'(200 + i), 1'b0);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL force_done_early: got %0b expected 0", done); end
    send(16'd214, 1'b0);
    checks++; if (done !== 1'b1 || wr_cnt - base !== 18) begin
      errors++; $display("FAIL force_done: got done=%0b writes=%0d expected 1 18", done, wr_cnt - base);
    end
    // force between samples: next sample becomes the trigger
    arm_cap(4'd0, 1'b0, 16'hFFFF);
    send(16'd7, 1'b0);
    pulse_force();
    send(16'd8, 1'b0);
    checks++; if (start_addr !== 4'd1) begin errors++; $display("FAIL force_pend_start: got %0d expected 1", start_addr); end
    for (int i = 0; i < 15; i++) send(16'(i), 1'b0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL force_pend_done: got %0b expected 1", done); end
    base = wr_cnt;
    pulse_force();
    send(16'd9, 1'b1);
    checks++; if (done !== 1'b1 || start_addr !== 4'd1 || wr_cnt !== base) begin
      errors++; $display("FAIL force_in_done: got done=%0b start=%0d writes=%0d expected 1 1 0", done, start_addr, wr_cnt - base);
    end
    // force in PRE is ignored: 13 ARMED samples would complete a false capture
    arm_cap(4'd3, 1'b0, 16'hFFFF);
    pulse_force();
    for (int i = 0; i < 16; i++) send(16'd1, 1'b0);
    checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL force_in_pre: got %b expected 10", {busy, done}); end
  endtask

  task automatic test_falling();
    arm_cap(4'd0, 1'b1, 16'd8);
    send(16'd12, 1'b0);
    send(16'd12, 1'b0);
    send(16'd3, 1'b0);
    checks++; if (start_addr !== 4'd2 || wr_bus.wr_addr !== 4'd2) begin
      errors++; $display("FAIL fall_trig: got start=%0d addr=%0d expected 2 2", start_addr, wr_bus.wr_addr);
    end
    send(16'd12, 1'b0);
    arm_cap(4'd0, 1'b1, 16'd8);
    send(16'd3, 1'b0);
    send(16'd2, 1'b0);
    send(16'd1, 1'b0);
    send(16'd12, 1'b0);
    send(16'd5, 1'b0);
    checks++; if (start_addr !== 4'd4 || wr_bus.wr_addr !== 4'd4) begin
      errors++; $display("FAIL fall_first_no_prev: got start=%0d addr=%0d expected 4 4", start_addr, wr_bus.wr_addr);
    end
  endtask

  task automatic test_rearm();
    arm_cap(4'd4, 1'b0, 16'd8);
    checks++; if ({busy, done} !== 2'b10 || wr_bus.wr_addr !== 4'd0 || start_addr !== 4'd0) begin
      errors++; $display("FAIL rearm_clear: got busy/done=%b addr=%0d start=%0d expected 10 0 0", {busy, done}, wr_bus.wr_addr, start_addr);
    end
    send(16'd0, 1'b0);
    send(16'd9, 1'b0);
    send(16'd0, 1'b0);
    send(16'd0, 1'b0);
    send(16'd5, 1'b0);
    send(16'd9, 1'b0);
    checks++; if (start_addr !== 4'd1 || wr_bus.wr_addr !== 4'd5) begin
      errors++; $display("FAIL rearm_trig: got start=%0d addr=%0d expected 1 5", start_addr, wr_bus.wr_addr);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    arm_cap(4'd0, 1'b0, 16'hFFFF);
    send(16'd1, 1'b0);
    send(16'd2, 1'b0);
    @(negedge clk);
    adc_valid = 1'b1; adc_data = 16'd3;
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checks++; if (wr_bus.wr_en !== 1'b0 || wr_bus.wr_addr !== 4'd0 || wr_bus.wr_data !== 16'd0 || start_addr !== 4'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_async: got en=%0b addr=%0d data=%0d start=%0d busy=%0b expected all 0",
                         wr_bus.wr_en, wr_bus.wr_addr, wr_bus.wr_data, start_addr, busy);
    end
    adc_valid = 1'b0;
    #1;
    base = wr_cnt;
    send(16'd4, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    send(16'd5, 1'b0);
    checks++; if (wr_cnt !== base || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_abort: got writes=%0d busy=%0b done=%0b expected 0 0 0", wr_cnt - base, busy, done);
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_addr;
    arm_cap(4'd0, 1'b0, 16'hFFFF);
    for (int i = 0; i < 40; i++) begin
      send(16'(i), 1'b0);
      exp_addr = AW'(i);
      checks++; if (wr_bus.wr_addr !== exp_addr || busy !== 1'b1) begin
        errors++; $display("FAIL wrap_%0d: got addr=%0d busy=%0b expected %0d 1", i, wr_bus.wr_addr, busy, exp_addr);
      end
    end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL wrap_done: got %0b expected 0", done); end
  endtask

  initial begin
    test_reset();
    test_pretrig_rising();
    test_force();
    test_falling();
    test_rearm();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
